serial_subtractor: RTL



---
 rtl/serial_subtractor_pkg.sv | 24 ++
 rtl/serial_subtractor_if.sv | 38 +++
 rtl/serial_subtractor_cell.sv | 14 +
 rtl/serial_subtractor.sv | 138 +++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t       : controller state (IDLE / BUSY / DONE), 2 bits
//   DEFAULT_WIDTH : default operand/result width
//   clog2()       : bit count needed to index WIDTH serial steps
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
//   io_in_valid/io_in_ready   : operand pair handshake (io_a minuend, io_b subtrahend)
//   io_out_valid/io_out_ready : result handshake (io_d difference, io_bout borrow-out)
//   io_ovf                    : signed overflow, present only with SERIAL_SUB_OVF_EN
// Modports: master = producer/consumer side, slave = the subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = serial_sub_pkg::DEFAULT_WIDTH
);
    logic             io_in_valid;
    logic             io_in_ready;
    logic [WIDTH-1:0] io_a;
    logic [WIDTH-1:0] io_b;
    logic             io_out_valid;
    logic             io_out_ready;
    logic [WIDTH-1:0] io_d;
    logic             io_bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             io_ovf;

    modport master (
        output io_in_valid, io_a, io_b, io_out_ready,
        input  io_in_ready, io_out_valid, io_d, io_bout, io_ovf
    );
    modport slave (
        input  io_in_valid, io_a, io_b, io_out_ready,
        output io_in_ready, io_out_valid, io_d, io_bout, io_ovf
    );
`else
    modport master (
        output io_in_valid, io_a, io_b, io_out_ready,
        input  io_in_ready, io_out_valid, io_d, io_bout
    );
    modport slave (
        input  io_in_valid, io_a, io_b, io_out_ready,
        output io_in_ready, io_out_valid, io_d, io_bout
    );
`endif
endinterface

// File: rtl/serial_subtractor_cell.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
//   a, b, bin : minuend bit, subtrahend bit, borrow-in
//   d, bout   : difference bit, borrow-out
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    // Borrow when a<b outright, or when a==b and a borrow is already pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: io_d = (io_a - io_b) mod 2^WIDTH, LSB first,
// one bit per clock, with io_bout = 1 when io_a < io_b (unsigned).
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   io    : serial_subtractor_if.slave (operand and result handshakes)
// Optional macro SERIAL_SUB_OVF_EN adds io_ovf, the two's-complement overflow
// flag captured at the last bit alongside io_d.
// Timing: operands accepted on edge 0, io_out_valid rises after edge WIDTH and
// holds until io_out_ready. io_d/io_bout keep the last result afterwards.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic                 clock,
    input logic                 reset,
    serial_subtractor_if.slave  io
);
    localparam int             CW   = clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    // Holds the WIDTH-1 low difference bits produced so far; the final bit
    // joins them directly on the way into d_q.
    logic [WIDTH-2:0]   res_q, res_d;
    logic [WIDTH-1:0]   res_ext;
    logic               borrow_q, borrow_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic               bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic cell_d;
    logic cell_bout;

    full_subtractor_cell u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        d_d      = d_q;
        bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d    = ovf_q;
`endif
        res_ext  = {cell_d, res_q};

        unique case (state_q)
            IDLE: begin
                if (io.io_in_valid) begin
                    a_d      = io.io_a;
                    b_d      = io.io_b;
                    res_d    = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                res_d    = res_ext[WIDTH-1:1];
                borrow_d = cell_bout;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // Publish only the completed value so no partial result
                    // ever appears on io_d.
                    d_d     = res_ext;
                    bout_d  = cell_bout;
                    cnt_d   = '0;
                    state_d = DONE;
`ifdef SERIAL_SUB_OVF_EN
                    // a_q[0]/b_q[0] are the original sign bits at this step.
                    ovf_d   = (a_q[0] ^ b_q[0]) & (a_q[0] ^ cell_d);
`endif
                end
            end
            DONE: begin
                if (io.io_out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            d_q      <= '0;
            bout_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            d_q      <= d_d;
            bout_q   <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign io.io_in_ready  = (state_q == IDLE);
    assign io.io_out_valid = (state_q == DONE);
    assign io.io_d         = d_q;
    assign io.io_bout      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign io.io_ovf       = ovf_q;
`endif

endmodule
